mem_access_stage: RTL

- MEM pipeline stage. Consumes the EX-stage result bundle: ALU result, effective address, control bits and destination register.
- Performs word loads/stores on a req/ack data-memory port with variable latency, stalling upstream while an access is outstanding.
- Delivers a one-cycle write-back bundle to the WB stage.
- Non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_access_stage.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: word load/store over a req/ack data port with timeout
module mem_access_stage #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_2_mem,
    input  logic [31:0]       rd_2_mem,
    input  logic [31:0]       A_2_mem,
    input  logic              mem_read_2_mem,
    input  logic              mem_write_2_mem,
    input  logic              mem_to_reg_2_mem,
    input  logic              reg_write_2_mem,
    input  logic [4:0]        rd_add_value_2_mem,
    output logic              stall_out,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic [4:0]        wb_rd_add,
    output logic              wb_reg_write,
    output logic              misalign_err,
    output logic              bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic              reg_write_q, reg_write_d;
    logic [4:0]        rd_add_q, rd_add_d;
    logic              wb_valid_q, wb_valid_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic [4:0]        wb_rd_add_q, wb_rd_add_d;
    logic              wb_reg_write_q, wb_reg_write_d;
    logic              misalign_q, misalign_d;
    logic              bus_err_q, bus_err_d;

    logic is_mem_op;
    assign is_mem_op = mem_read_2_mem | mem_write_2_mem;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            mem_to_reg_q   <= 1'b0;
            reg_write_q    <= 1'b0;
            rd_add_q       <= '0;
            wb_valid_q     <= 1'b0;
            wb_data_q      <= '0;
            wb_rd_add_q    <= '0;
            wb_reg_write_q <= 1'b0;
            misalign_q     <= 1'b0;
            bus_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            req_q          <= req_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            mem_to_reg_q   <= mem_to_reg_d;
            reg_write_q    <= reg_write_d;
            rd_add_q       <= rd_add_d;
            wb_valid_q     <= wb_valid_d;
            wb_data_q      <= wb_data_d;
            wb_rd_add_q    <= wb_rd_add_d;
            wb_reg_write_q <= wb_reg_write_d;
            misalign_q     <= misalign_d;
            bus_err_q      <= bus_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        req_d          = req_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        mem_to_reg_d   = mem_to_reg_q;
        reg_write_d    = reg_write_q;
        rd_add_d       = rd_add_q;
        wb_valid_d     = 1'b0;
        wb_data_d      = wb_data_q;
        wb_rd_add_d    = wb_rd_add_q;
        wb_reg_write_d = wb_reg_write_q;
        misalign_d     = 1'b0;
        bus_err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_2_mem) begin
                    if (is_mem_op) begin
                        // Read wins when both read and write are set; low address bits are dropped.
                        state_d      = ACCESS;
                        cnt_d        = '0;
                        req_d        = 1'b1;
                        we_d         = mem_write_2_mem & ~mem_read_2_mem;
                        addr_d       = A_2_mem[ADDR_W+1:2];
                        wdata_d      = rd_2_mem;
                        mem_to_reg_d = mem_to_reg_2_mem;
                        reg_write_d  = reg_write_2_mem;
                        rd_add_d     = rd_add_value_2_mem;
                        misalign_d   = |A_2_mem[1:0];
                    end else begin
                        wb_valid_d     = 1'b1;
                        wb_data_d      = rd_2_mem;
                        wb_rd_add_d    = rd_add_value_2_mem;
                        wb_reg_write_d = reg_write_2_mem;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                if (dmem_ack) begin
                    state_d        = IDLE;
                    cnt_d          = '0;
                    req_d          = 1'b0;
                    wb_valid_d     = 1'b1;
                    wb_data_d      = mem_to_reg_q ? dmem_rdata : wdata_q;
                    wb_rd_add_d    = rd_add_q;
                    wb_reg_write_d = reg_write_q & ~we_q;
                end else if (cnt_q == CNT_LAST) begin
                    // This is the TIMEOUT-th request cycle without an ack.
                    state_d        = IDLE;
                    cnt_d          = '0;
                    req_d          = 1'b0;
                    wb_valid_d     = 1'b1;
                    wb_rd_add_d    = rd_add_q;
                    wb_reg_write_d = 1'b0;
                    bus_err_d      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall_out    = (state_q == ACCESS);
    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_data      = wb_data_q;
    assign wb_rd_add    = wb_rd_add_q;
    assign wb_reg_write = wb_reg_write_q;
    assign misalign_err = misalign_q;
    assign bus_err      = bus_err_q;

endmodule
